// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte handshake and status bundle
//   out     : received byte (master -> slave)
//   valid   : out holds an unconsumed byte (master -> slave)
//   error   : sticky framing error (master -> slave)
//   overrun : a byte was overwritten while still pending (master -> slave)
//   ready   : consumer accepts the byte when high with valid (slave -> master)
interface uart_receiver_if;
   logic [7:0] out;
   logic       valid;
   logic       ready;
   logic       error;
   logic       overrun;
   modport master (output out, valid, error, overrun, input ready);
   modport slave  (input out, valid, error, overrun, output ready);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first serial receiver with valid/ready output, framing error and overrun
//   clk    : system clock, rising edge
//   reset  : async active-high reset
//   enable : receiver enable, low aborts any frame and parks the FSM in IDLE
//   in     : serial line, idle high
//   bus    : uart_receiver_if.master (out, valid, error, overrun, ready)
// Define UART_RX_SYNC_EN to pass in through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_receiver #(
   parameter int CLOCK_RATE = 24000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              in,
   uart_receiver_if.master   bus
);
   localparam int DIV  = CLOCK_RATE / BAUD_RATE;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          rx;
   logic          half_done;
   logic          bit_done;
`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clk or posedge reset)
      if (reset) sync <= 2'b11;
      else sync <= {sync[0], in};
   assign rx = sync[1];
`else
   assign rx = in;
`endif
   // START waits HALF+1 edges so the start bit is sampled near its centre;
   // DATA/STOP then step a full bit period from that point.
   assign half_done = cnt == CW'(HALF);
   assign bit_done  = cnt == CW'(DIV - 1);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         bus.out     <= '0;
         bus.valid   <= 1'b0;
         bus.error   <= 1'b0;
         bus.overrun <= 1'b0;
      end else begin
         if (bus.valid && bus.ready) begin
            bus.valid   <= 1'b0;
            bus.overrun <= 1'b0;
         end
         if (!enable) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (!rx) begin
                  state <= START;
                  cnt   <= '0;
               end
               START: if (half_done) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= rx ? IDLE : DATA;
                  if (!rx) bus.error <= 1'b0;
               end else cnt <= cnt + CW'(1);
               DATA: if (bit_done) begin
                  cnt     <= '0;
                  shift   <= {rx, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else cnt <= cnt + CW'(1);
               // Leaving at mid-stop-bit lets IDLE catch a start edge right after it.
               STOP: if (bit_done) begin
                  cnt <= '0;
                  if (rx) begin
                     bus.out     <= shift;
                     bus.valid   <= 1'b1;
                     bus.overrun <= bus.valid && !bus.ready;
                     state       <= IDLE;
                  end else begin
                     bus.error <= 1'b1;
                     state     <= BREAK;
                  end
               end else cnt <= cnt + CW'(1);
               BREAK: if (rx) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed scoreboard bench for uart_receiver at default rates
module tb_uart_receiver;
   localparam int DIV  = 24000000 / 115200;
   localparam int HALF = DIV / 2;
`ifdef UART_RX_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif
   localparam int L = S + 1 + HALF + 9 * DIV;
   logic clk;
   logic reset;
   logic enable;
   logic line;
   int vectors;
   int miscompares;
   logic [7:0] q[$];
   logic [7:0] m_out;
   logic m_err;
   logic m_ovr;
   uart_receiver_if bus ();
   uart_receiver dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .in     (line),
      .bus    (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag);
      chk({tag, "_valid"}, 32'(bus.valid), 32'(q.size() != 0));
      chk({tag, "_out"}, 32'(bus.out), 32'(m_out));
      chk({tag, "_error"}, 32'(bus.error), 32'(m_err));
      chk({tag, "_overrun"}, 32'(bus.overrun), 32'(m_ovr));
   endtask
   // Starts at a negedge; the following posedge is T0.
   task automatic frame(input logic [7:0] b, input logic stop, input string tag);
      line = 1'b0;
      repeat (DIV) @(negedge clk);
      m_err = 1'b0;
      chk({tag, "_err_at_start"}, 32'(bus.error), 32'(m_err));
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         repeat (DIV) @(negedge clk);
      end
      line = stop;
      repeat (S + 1 + HALF) @(negedge clk);
      chk({tag, "_valid_early"}, 32'(bus.valid), 32'(q.size() != 0));
      @(negedge clk);
      if (stop) begin
         if (q.size() != 0) begin
            void'(q.pop_front());
            m_ovr = 1'b1;
         end
         q.push_back(b);
         m_out = b;
      end else m_err = 1'b1;
      chk_all(tag);
      repeat (10 * DIV - 1 - L) @(negedge clk);
      line = 1'b1;
      repeat (4) @(negedge clk);
   endtask
   task automatic consume(input string tag);
      logic [7:0] exp;
      chk({tag, "_pending"}, 32'(bus.valid), 32'd1);
      exp = (q.size() != 0) ? q.pop_front() : 8'h00;
      chk({tag, "_data"}, 32'(bus.out), 32'(exp));
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      m_ovr = 1'b0;
      chk_all({tag, "_after"});
   endtask
   initial begin
      vectors = 0;
      miscompares = 0;
      clk = 1'b0;
      reset = 1'b1;
      enable = 1'b1;
      line = 1'b1;
      bus.ready = 1'b0;
      m_out = 8'h00;
      m_err = 1'b0;
      m_ovr = 1'b0;
      repeat (3) @(negedge clk);
      chk_all("reset");
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk_all("idle");
      frame(8'hA5, 1'b1, "a5");
      consume("a5_take");
      frame(8'h31, 1'b1, "ovr1");
      frame(8'h20, 1'b1, "ovr2");
      chk("ovr_flag", 32'(bus.overrun), 32'd1);
      consume("ovr_take");
      frame(8'h30, 1'b0, "bad_stop");
      chk("bad_stop_err", 32'(bus.error), 32'd1);
      frame(8'h31, 1'b1, "recover");
      line = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         line = i[0];
         repeat (DIV) @(negedge clk);
      end
      line = 1'b0;
      repeat (HALF) @(negedge clk);
      reset = 1'b1;
      #1;
      q.delete();
      m_out = 8'h00;
      m_err = 1'b0;
      m_ovr = 1'b0;
      chk_all("midreset");
      line = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (DIV) @(negedge clk);
      frame(8'h55, 1'b1, "post_reset");
      consume("post_reset_take");
      line = 1'b0;
      repeat (40) @(negedge clk);
      line = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      chk_all("glitch");
      line = 1'b0;
      repeat (DIV) @(negedge clk);
      line = 1'b1;
      repeat (3 * DIV + HALF) @(negedge clk);
      enable = 1'b0;
      repeat (10) @(negedge clk);
      chk_all("disabled");
      enable = 1'b1;
      repeat (7 * DIV) @(negedge clk);
      chk_all("aborted");
      frame(8'h0F, 1'b1, "en_0f");
      consume("en_0f_take");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
